codeword_tx: RTL
================

Name: codeword_tx

Overview:
- Serial codeword transmitter; the transmit-side counterpart of the team's serial codeword detector.
- Emits one bit per bit-enable tick onto a single serial line.
- When idle, fills the line with LFSR pseudo-random bits.
- On request, inserts a CW_WIDTH-bit codeword MSB-first, followed by a run of zero guard bits, then returns to filler.
- Drives the detector's serial input in system tests and loopback.

Parameters:
- CW_WIDTH, 8, codeword length in bits (2..32).
- GUARD_BITS, 2, zero bits sent after each codeword (0..15); 0 disables the guard.
- FILL_EN, 1, 1 = LFSR filler when idle; 0 = constant 0 when idle.
- LFSR_SEED, 7'h5A, LFSR reset value; 0 is illegal and is forced to 7'h01.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, synchronous, active-low.
- bit_en, input, 1, bit tick; all line activity advances only on cycles where this is high.
- send, input, 1, codeword request; sampled every cycle.
- cw_in, input, CW_WIDTH, codeword; latched when send is accepted.
- busy, output, 1, high from the cycle after acceptance until return to IDLE.
- done, output, 1, one-cycle pulse on completion.
- tx_bit, output, 1, serial line, registered.
- cw_active, output, 1, high while tx_bit carries a codeword bit (parity bit included).

Behaviour:
- Reset values: state IDLE, lfsr = LFSR_SEED (or 7'h01 if the seed is 0), tx_bit 0, busy 0, done 0, cw_active 0, bit counter 0.
- All outputs are registered.
- LFSR: 7-bit Fibonacci, polynomial x^7+x^6+1, shifts left, feedback = lfsr[6]^lfsr[5], output = lfsr[6].
  - Advances only in IDLE on bit_en.
  - Holds its value in all other states.
- IDLE:
  - On each bit_en, tx_bit <= (FILL_EN ? lfsr[6] : 0) and cw_active <= 0.
  - send=1 is accepted: cw_reg <= cw_in, cnt <= CW_WIDTH-1, next state SEND, busy <= 1.
  - If the acceptance cycle also has bit_en, that tick still emits a filler bit. The first codeword bit appears on the next bit_en after acceptance.
- SEND:
  - On bit_en: tx_bit <= cw_reg[cnt], cw_active <= 1.
  - If cnt == 0, go to GUARD (GUARD_BITS>0) or FIN; otherwise cnt <= cnt-1.
  - Holds while bit_en=0.
- GUARD: on bit_en, tx_bit <= 0, cw_active <= 0, gcnt counts up. After GUARD_BITS ticks, go to FIN.
- FIN:
  - Single cycle, independent of bit_en: done <= 1, busy <= 0, state IDLE.
  - tx_bit holds its last value until the next bit_en.
- Request rules:
  - send while busy (SEND/GUARD/FIN) is ignored; nothing is queued and cw_in is not re-latched.
  - send held high continuously re-triggers in the IDLE cycle after FIN: back-to-back frames with zero filler bits between them.
- Reset mid-frame: the frame is aborted immediately, done is not pulsed, and the line returns to the reset state.
- Latency: acceptance to the first codeword bit is 1 bit_en tick. A frame spans CW_WIDTH+GUARD_BITS ticks, plus 1 if parity is enabled.
- Counter widths: cnt is $clog2(CW_WIDTH) bits; gcnt is 4 bits.

Optional Feature:
- Macro: CODEWORD_TX_PARITY_EN.
- Defined:
  - After the last codeword bit, one extra SEND-phase tick emits the even-parity bit (^cw_reg), with cw_active=1.
  - Guard bits follow the parity bit.
  - Frame length becomes CW_WIDTH+1+GUARD_BITS.
- Undefined: no parity state or logic is present; frame length is CW_WIDTH+GUARD_BITS.

Decomposition:
- Shared package codeword_pkg holds:
  - enum type tx_state_t {IDLE, SEND, PARITY, GUARD, FIN}; PARITY is used only when CODEWORD_TX_PARITY_EN is defined.
  - CW_DEFAULT = 8'b1011_1111, the detector's target pattern.
  - LFSR_W = 7.
  - LFSR_TAPS = 7'b110_0000.
- Sub-module: lfsr7_filler, with ports clk, rst_n, adv, seed, bit_out. It is reusable by the detector bench.

Test Plan:
- Reset/filler: hold rst_n=0 for 3 cycles, then bit_en=1 continuously with FILL_EN=1 and seed 7'h5A. The first 7 filler bits must be 1,0,1,1,0,1,0; the sequence period must be 127.
- Basic frame: in IDLE, pulse send with cw_in=8'hBF and bit_en every cycle. Required response:
  - tx_bit = 1,0,1,1,1,1,1,1 with cw_active=1.
  - Then 0,0 (guard) with cw_active=0.
  - done is high for 1 cycle; busy is high for exactly 11 cycles.
- Sparse tick: bit_en every 4th cycle, cw_in=8'hA5. Bits 1,0,1,0,0,1,0,1 are each held for 4 cycles; the LFSR is frozen during the frame.
- Busy collision: send cw_in=8'h0F, then pulse send with 8'hF0 at the 3rd codeword bit. The full 0000_1111 frame must complete; 8'hF0 is never sent; exactly one done pulse.
- Reset mid-frame: assert rst_n=0 at the 5th codeword bit. The next cycle shows tx_bit=0, busy=0, state IDLE, no done pulse, and lfsr=seed.
- Parity (macro defined): cw_in=8'hBF. After 8 data bits, tx_bit=1 (seven ones, so even parity is 1) with cw_active=1, then 2 guard zeros; done arrives 12 cycles after acceptance.

Source files
------------

// File: rtl/codeword_pkg.sv
// Shared types and constants for the serial codeword transmitter and detector.
package codeword_pkg;

  typedef enum logic [2:0] {IDLE, SEND, PARITY, GUARD, FIN} tx_state_t;

  localparam logic [7:0] CW_DEFAULT = 8'b1011_1111;
  localparam int LFSR_W = 7;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'b110_0000;

  // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr7_filler.sv
// 7-bit x^7+x^6+1 pseudo-random filler source; advances only when adv is high.
module lfsr7_filler
  import codeword_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic [LFSR_W-1:0] seed,
  output logic              bit_out
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] seed_safe;

  // An all-zero state would lock the register, so a zero seed becomes 1.
  assign seed_safe = (seed == '0) ? LFSR_W'(1) : seed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= seed_safe;
    end else if (adv) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  assign bit_out = lfsr[LFSR_W-1];

endmodule

// File: rtl/codeword_tx.sv
// Serial codeword transmitter: LFSR filler when idle, MSB-first codeword plus zero guard on request.
// Define CODEWORD_TX_PARITY_EN to append an even-parity bit after the codeword.
module codeword_tx
  import codeword_pkg::*;
#(
  parameter int                CW_WIDTH   = 8,
  parameter int                GUARD_BITS = 2,
  parameter bit                FILL_EN    = 1'b1,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 7'h5A
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bit_en,
  input  logic                send,
  input  logic [CW_WIDTH-1:0] cw_in,
  output logic                busy,
  output logic                done,
  output logic                tx_bit,
  output logic                cw_active
);

  localparam int CNT_W = $clog2(CW_WIDTH);

  tx_state_t           state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [3:0]          gcnt, gcnt_n;
  logic [CW_WIDTH-1:0] cw_reg;
  logic                load;
  logic                tx_n, act_n, busy_n, done_n;
  logic                fill_bit;
  logic                lfsr_adv;
  tx_state_t           after_data;

  // Filler is frozen for the whole frame so it resumes where it left off.
  assign lfsr_adv = (state == IDLE) && bit_en;

  lfsr7_filler u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (lfsr_adv),
    .seed    (LFSR_SEED),
    .bit_out (fill_bit)
  );

  assign after_data = (GUARD_BITS > 0) ? GUARD : FIN;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    tx_n    = tx_bit;
    act_n   = cw_active;
    busy_n  = busy;
    done_n  = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bit_en) begin
          tx_n  = FILL_EN ? fill_bit : 1'b0;
          act_n = 1'b0;
        end
        if (send) begin
          load    = 1'b1;
          cnt_n   = CNT_W'(CW_WIDTH - 1);
          busy_n  = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (bit_en) begin
          tx_n  = cw_reg[cnt];
          act_n = 1'b1;
          if (cnt == '0) begin
`ifdef CODEWORD_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = after_data;
`endif
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
`ifdef CODEWORD_TX_PARITY_EN
      PARITY: begin
        if (bit_en) begin
          tx_n    = ^cw_reg;
          act_n   = 1'b1;
          state_n = after_data;
        end
      end
`endif
      GUARD: begin
        if (bit_en) begin
          tx_n  = 1'b0;
          act_n = 1'b0;
          if (gcnt == 4'(GUARD_BITS - 1)) begin
            gcnt_n  = '0;
            state_n = FIN;
          end else begin
            gcnt_n = gcnt + 1'b1;
          end
        end
      end
      FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gcnt      <= '0;
      tx_bit    <= 1'b0;
      cw_active <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gcnt      <= gcnt_n;
      tx_bit    <= tx_n;
      cw_active <= act_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      cw_reg <= cw_in;
    end
  end

endmodule
